// File: rtl/exp_adder_pkg.sv
// Shared posit definitions: default field widths, the scale-combiner state
// encoding, and the saturation limit of the posit scale range.
package exp_adder_pkg;

    localparam int DEFAULT_ES     = 3;
    localparam int DEFAULT_K_BITS = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Largest representable scale magnitude: (2^(K_BITS-1) - 2) << ES.
    function automatic int max_scale(input int es, input int k_bits);
        return ((1 << (k_bits - 1)) - 2) << es;
    endfunction

endpackage

// File: rtl/posit_scale.sv
// Combinational posit scale converter: scale = sign-extend(k) * 2^ES + exp.
// The exponent field is unsigned and exactly ES bits wide, so the product plus
// sum reduces to concatenating the sign-extended regime above the exponent.
module posit_scale #(
    parameter int ES     = 3,
    parameter int K_BITS = 6,
    parameter int OUT_W  = ES + K_BITS + 1
) (
    input  logic        [K_BITS-1:0] k,
    input  logic        [ES-1:0]     exp,
    output logic signed [OUT_W-1:0]  scale
);

    localparam int EXT_BITS = OUT_W - K_BITS - ES;

    assign scale = {{EXT_BITS{k[K_BITS-1]}}, k, exp};

endmodule

// File: rtl/exp_adder.sv
// Multi-cycle scale combiner for the posit multiplier: adds the two operand
// scales, derives the product sign and flags overflow (NaR) / underflow (zero).
module exp_adder
    import exp_adder_pkg::*;
#(
    parameter int ES       = DEFAULT_ES,
    parameter int K_BITS   = DEFAULT_K_BITS,
    parameter int MAX_BITS = ES + K_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ES-1:0]       exp_A,
    input  logic [ES-1:0]       exp_B,
    input  logic [K_BITS-1:0]   k_A,
    input  logic [K_BITS-1:0]   k_B,
    input  logic                sign_A,
    input  logic                sign_B,
    output logic [MAX_BITS:0]   exp_raw,
    output logic                sign_out,
    output logic                NaR,
    output logic                zero_out,
    output logic                done
);

    localparam int MAX_SCALE = max_scale(ES, K_BITS);
    localparam logic signed [MAX_BITS:0] POS_LIMIT = (MAX_BITS + 1)'(MAX_SCALE);
    localparam logic signed [MAX_BITS:0] NEG_LIMIT = -POS_LIMIT;

    logic [1:0] cur_state;

    // Operands captured at start so the decoders upstream may move on.
    logic [K_BITS-1:0] op_k_a;
    logic [K_BITS-1:0] op_k_b;
    logic [ES-1:0]     op_exp_a;
    logic [ES-1:0]     op_exp_b;
    logic              op_sign_a;
    logic              op_sign_b;

    logic signed [MAX_BITS:0] scale_a;
    logic signed [MAX_BITS:0] scale_b;
    logic signed [MAX_BITS:0] sum;
    logic                     over;
    logic                     under;

    posit_scale #(
        .ES    (ES),
        .K_BITS(K_BITS),
        .OUT_W (MAX_BITS + 1)
    ) u_scale_a (
        .k    (op_k_a),
        .exp  (op_exp_a),
        .scale(scale_a)
    );

    posit_scale #(
        .ES    (ES),
        .K_BITS(K_BITS),
        .OUT_W (MAX_BITS + 1)
    ) u_scale_b (
        .k    (op_k_b),
        .exp  (op_exp_b),
        .scale(scale_b)
    );

    // Each scale spans one bit less than the sum, so the addition cannot wrap.
    assign sum   = scale_a + scale_b;
    assign over  = (sum > POS_LIMIT);
    assign under = (sum < NEG_LIMIT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            op_k_a    <= '0;
            op_k_b    <= '0;
            op_exp_a  <= '0;
            op_exp_b  <= '0;
            op_sign_a <= 1'b0;
            op_sign_b <= 1'b0;
            exp_raw   <= '0;
            sign_out  <= 1'b0;
            NaR       <= 1'b0;
            zero_out  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        op_k_a    <= k_A;
                        op_k_b    <= k_B;
                        op_exp_a  <= exp_A;
                        op_exp_b  <= exp_B;
                        op_sign_a <= sign_A;
                        op_sign_b <= sign_B;
                        cur_state <= CALC;
                    end
                end
                CALC: begin
                    exp_raw   <= sum;
                    NaR       <= over;
                    zero_out  <= under;
                    sign_out  <= (op_sign_a ^ op_sign_b) & ~over & ~under;
                    cur_state <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    cur_state <= IDLE;
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_adder.sv
// Self-checking bench for exp_adder: directed test-plan cases, boundaries,
// handshake control and randomized operands against an arithmetic model.
module tb_exp_adder;

    localparam int ES       = 3;
    localparam int K_BITS   = 6;
    localparam int MAX_BITS = ES + K_BITS;
    localparam int LIMIT    = ((1 << (K_BITS - 1)) - 2) * (1 << ES);

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ES-1:0]       exp_A;
    logic [ES-1:0]       exp_B;
    logic [K_BITS-1:0]   k_A;
    logic [K_BITS-1:0]   k_B;
    logic                sign_A;
    logic                sign_B;
    logic [MAX_BITS:0]   exp_raw;
    logic                sign_out;
    logic                NaR;
    logic                zero_out;
    logic                done;

    int checks = 0;
    int errors = 0;

    int   last_sum;
    logic last_nar;
    logic last_zero;
    logic last_sign;

    exp_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .exp_A   (exp_A),
        .exp_B   (exp_B),
        .k_A     (k_A),
        .k_B     (k_B),
        .sign_A  (sign_A),
        .sign_B  (sign_B),
        .exp_raw (exp_raw),
        .sign_out(sign_out),
        .NaR     (NaR),
        .zero_out(zero_out),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scale of one operand as a plain integer: k * 2^ES + exp.
    function automatic int ref_scale(input logic [K_BITS-1:0] k, input logic [ES-1:0] e);
        return int'($signed(k)) * (1 << ES) + int'(e);
    endfunction

    task automatic scramble_inputs();
        k_A    = K_BITS'($urandom);
        k_B    = K_BITS'($urandom);
        exp_A  = ES'($urandom);
        exp_B  = ES'($urandom);
        sign_A = 1'($urandom);
        sign_B = 1'($urandom);
    endtask

    task automatic check_results(input string tag);
        check($sformatf("%s.exp_raw", tag), $signed(exp_raw), last_sum);
        check($sformatf("%s.NaR", tag), NaR, last_nar);
        check($sformatf("%s.zero_out", tag), zero_out, last_zero);
        check($sformatf("%s.sign_out", tag), sign_out, last_sign);
    endtask

    task automatic set_expected(input logic [K_BITS-1:0] ka, input logic [ES-1:0] ea,
                                input logic [K_BITS-1:0] kb, input logic [ES-1:0] eb,
                                input logic sa, input logic sb);
        last_sum  = ref_scale(ka, ea) + ref_scale(kb, eb);
        last_nar  = last_sum > LIMIT;
        last_zero = last_sum < -LIMIT;
        last_sign = (sa ^ sb) && !last_nar && !last_zero;
    endtask

    // One full transaction with exact-latency checks on done and the results.
    task automatic run_op(input int ka, input int ea, input int kb, input int eb,
                          input logic sa, input logic sb, input string tag);
        logic [K_BITS-1:0] k6a;
        logic [K_BITS-1:0] k6b;
        logic [ES-1:0]     e3a;
        logic [ES-1:0]     e3b;
        k6a = ka[K_BITS-1:0];
        k6b = kb[K_BITS-1:0];
        e3a = ea[ES-1:0];
        e3b = eb[ES-1:0];
        set_expected(k6a, e3a, k6b, e3b, sa, sb);
        @(negedge clk);
        k_A = k6a; exp_A = e3a; sign_A = sa;
        k_B = k6b; exp_B = e3b; sign_B = sb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check($sformatf("%s.done_n0", tag), done, 1'b0);
        @(negedge clk);
        check($sformatf("%s.done_n1", tag), done, 1'b0);
        @(negedge clk);
        check($sformatf("%s.done_n2", tag), done, 1'b1);
        check_results(tag);
        @(negedge clk);
        check($sformatf("%s.done_n3", tag), done, 1'b0);
        check($sformatf("%s.held_exp_raw", tag), $signed(exp_raw), last_sum);
    endtask

    initial begin
        int done_count;

        rst_n = 1'b0;
        start = 1'b0;
        k_A = '0; k_B = '0; exp_A = '0; exp_B = '0; sign_A = 1'b0; sign_B = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.exp_raw", $signed(exp_raw), 0);
        check("reset.sign_out", sign_out, 1'b0);
        check("reset.NaR", NaR, 1'b0);
        check("reset.zero_out", zero_out, 1'b0);
        check("reset.done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the test plan.
        run_op(2, 3, 1, 2, 1'b0, 1'b0, "basic");
        run_op(-2, 1, 3, 2, 1'b0, 1'b1, "neg_k");
        run_op(10, 5, -5, 2, 1'b0, 1'b1, "mixed");
        run_op(29, 6, 0, 1, 1'b1, 1'b0, "just_below");
        run_op(25, 7, 4, 6, 1'b1, 1'b0, "just_over");
        run_op(28, 7, 28, 7, 1'b0, 1'b1, "big_over");
        run_op(-30, 0, -30, 0, 1'b1, 1'b0, "under");
        run_op(30, 0, 0, 0, 1'b1, 1'b0, "pos_edge");
        run_op(-30, 0, 0, 0, 1'b0, 1'b1, "neg_edge");
        run_op(-30, 0, -1, 7, 1'b0, 1'b1, "neg_edge_m1");
        run_op(30, 0, 0, 1, 1'b0, 1'b1, "pos_edge_p1");
        run_op(-32, 0, -32, 0, 1'b1, 1'b1, "min_sum");
        run_op(31, 7, 31, 7, 1'b1, 1'b0, "max_sum");

        // Outputs hold after done while inputs wander and start stays low.
        repeat (4) begin
            @(negedge clk);
            scramble_inputs();
        end
        check_results("hold");
        check("hold.done", done, 1'b0);

        // start held through CALC and DONE produces exactly one pulse.
        set_expected(6'd5, 3'd4, 6'd3, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        k_A = 6'd5; exp_A = 3'd4; k_B = 6'd3; exp_B = 3'd1; sign_A = 1'b1; sign_B = 1'b0;
        start = 1'b1;
        done_count = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_count++;
        end
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("held_start.pulses", done_count, 1);
        check_results("held_start");

        // Reset during CALC clears everything at once.
        @(negedge clk);
        k_A = 6'd7; exp_A = 3'd2; k_B = 6'd1; exp_B = 3'd3; sign_A = 1'b0; sign_B = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.exp_raw", $signed(exp_raw), 0);
        check("rst_mid.sign_out", sign_out, 1'b0);
        check("rst_mid.NaR", NaR, 1'b0);
        check("rst_mid.zero_out", zero_out, 1'b0);
        check("rst_mid.done", done, 1'b0);
        check("rst_mid.state", dut.cur_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("rst_mid.no_done", done_count, 0);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
